// File: rtl/wiegand_tx.sv
// Wiegand frame transmitter: latches a frame on start and serialises it MSB-first
// as D0/D1 pulses, with optional leading-even / trailing-odd parity insertion.
module wiegand_tx #(
    parameter int FRAME_BITS  = 26,
    parameter int PULSE_CYC   = 500,
    parameter int PERIOD_CYC  = 2200,
    parameter int GAP_CYC     = 20000,
    parameter int AUTO_PARITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [FRAME_BITS-1:0] data,
    output logic [1:0]            wigend,
    output logic                  busy,
    output logic                  done
);

    localparam int MAX_CYC = (PERIOD_CYC > GAP_CYC) ? PERIOD_CYC : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int IW      = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SPACE_END = CW'(PERIOD_CYC - PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SPACE,
        GAP
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   frame_in;
    logic                    par_hi;
    logic                    par_lo;

    // Upper half (below the leading bit) feeds even parity, lower half (above the
    // trailing bit) feeds odd parity.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        par_hi   = 1'b0;
        par_lo   = 1'b1;
        frame_in = data;
        for (int i = 1; i < FRAME_BITS - 1; i++) begin
            if (i >= FRAME_BITS / 2) par_hi = par_hi ^ data[i];
            else                     par_lo = par_lo ^ data[i];
        end
        if (AUTO_PARITY != 0) begin
            frame_in[FRAME_BITS-1] = par_hi;
            frame_in[0]            = par_lo;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            wigend <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // Truncate whatever is on the line; no completion pulse.
                state  <= IDLE;
                cnt    <= '0;
                idx    <= '0;
                wigend <= 2'b00;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            shreg  <= frame_in;
                            idx    <= '0;
                            cnt    <= '0;
                            wigend <= {frame_in[FRAME_BITS-1], ~frame_in[FRAME_BITS-1]};
                            busy   <= 1'b1;
                            state  <= PULSE;
                        end
                    end
                    PULSE: begin
                        if (cnt == PULSE_END) begin
                            cnt    <= '0;
                            wigend <= 2'b00;
                            state  <= (idx == LAST_BIT) ? GAP : SPACE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SPACE: begin
                        if (cnt == SPACE_END) begin
                            cnt    <= '0;
                            idx    <= idx + 1'b1;
                            shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
                            wigend <= {shreg[FRAME_BITS-2], ~shreg[FRAME_BITS-2]};
                            state  <= PULSE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_END) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wiegand_tx.sv
// Self-checking bench for wiegand_tx: directed and random frames compared cycle by
// cycle against a timing/parity model derived from the frame rules.
module tb_wiegand_tx;

    localparam int FB = 26, PU = 2, PE = 5, GA = 7;
    localparam int CFB = 34, CPU = 3, CPE = 11, CGA = 40;

    logic clk;
    logic rst;

    logic            start_a, abort_a, busy_a, done_a;
    logic [FB-1:0]   data_a;
    logic [1:0]      wig_a;
    logic            start_b, abort_b, busy_b, done_b;
    logic [FB-1:0]   data_b;
    logic [1:0]      wig_b;
    logic            start_c, abort_c, busy_c, done_c;
    logic [CFB-1:0]  data_c;
    logic [1:0]      wig_c;

    int checks = 0;
    int errors = 0;

    wiegand_tx #(.FRAME_BITS(FB), .PULSE_CYC(PU), .PERIOD_CYC(PE), .GAP_CYC(GA), .AUTO_PARITY(1)) u_par (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .data(data_a),
        .wigend(wig_a), .busy(busy_a), .done(done_a));

    wiegand_tx #(.FRAME_BITS(FB), .PULSE_CYC(PU), .PERIOD_CYC(PE), .GAP_CYC(GA), .AUTO_PARITY(0)) u_raw (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .data(data_b),
        .wigend(wig_b), .busy(busy_b), .done(done_b));

    wiegand_tx #(.FRAME_BITS(CFB), .PULSE_CYC(CPU), .PERIOD_CYC(CPE), .GAP_CYC(CGA), .AUTO_PARITY(1)) u_big (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .data(data_c),
        .wigend(wig_c), .busy(busy_c), .done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] obs_of(input int sel);
        case (sel)
            0:       return {wig_a, busy_a, done_a};
            1:       return {wig_b, busy_b, done_b};
            default: return {wig_c, busy_c, done_c};
        endcase
    endfunction

    // Reference frame: parity from population counts of the two half-fields.
    function automatic logic [63:0] model_frame(input logic [63:0] d, input int fb, input bit ap);
        logic [63:0] f, m;
        int half, hi, lo;
        f = d & ((64'd1 << fb) - 64'd1);
        if (!ap) return f;
        half = fb / 2;
        m    = (64'd1 << (half - 1)) - 64'd1;
        hi   = $countones((d >> half) & m);
        lo   = $countones((d >> 1) & m);
        f[fb-1] = (hi % 2) == 1;
        f[0]    = (lo % 2) == 0;
        return f;
    endfunction

    task automatic check(input string tag, input int t, input logic [3:0] got, input logic [3:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s t=%0d got=%b want=%b", tag, t, got, want);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_abort(input int sel, input logic v);
        case (sel)
            0:       abort_a = v;
            1:       abort_b = v;
            default: abort_c = v;
        endcase
    endtask

    task automatic set_data(input int sel, input logic [63:0] v);
        case (sel)
            0:       data_a = v[FB-1:0];
            1:       data_b = v[FB-1:0];
            default: data_c = v[CFB-1:0];
        endcase
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Raise start for one cycle; returns at the negedge of the first frame cycle.
    task automatic launch(input int sel);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
    endtask

    // Called at the negedge of the first cycle after acceptance (t=0). Pulse k is
    // high for t in [k*pe, k*pe+pu); done/busy-low lands at t=(fb-1)*pe+pu+ga.
    task automatic expect_frame(input int sel, input string tag, input logic [63:0] frame,
                                input int fb, input int pu, input int pe, input int ga,
                                input bit noisy, input int abort_at);
        int total, last, k, p;
        logic bitv;
        logic [3:0] want;
        total = (fb - 1) * pe + pu + ga;
        last  = (abort_at >= 0) ? abort_at + 10 : total;
        for (int t = 0; t <= last; t++) begin
            if (t > 0) @(negedge clk);
            if (abort_at >= 0 && t > abort_at) begin
                want = 4'b0000;
            end else if (t == total) begin
                want = 4'b0001;
            end else begin
                k = t / pe;
                p = t % pe;
                want = 4'b0010;
                if (k < fb && p < pu) begin
                    bitv = frame[fb-1-k];
                    want = {bitv, ~bitv, 2'b10};
                end
            end
            check(tag, t, obs_of(sel), want);
            if (abort_at >= 0) set_abort(sel, t == abort_at);
            if (noisy) begin
                set_start(sel, (t < total) ? 1'($urandom_range(0, 1)) : 1'b0);
                set_data(sel, rand64());
            end
        end
    endtask

    initial begin
        logic [63:0] r1, r2;
        rst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; data_a = '0;
        start_b = 1'b0; abort_b = 1'b0; data_b = '0;
        start_c = 1'b0; abort_c = 1'b0; data_c = '0;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check("reset", s, obs_of(s), 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) check("idle_after_reset", s, obs_of(s), 4'b0000);

        // Parity frame: outer bits of data are overwritten by parity.
        set_data(0, 64'h3FFE001);
        launch(0);
        expect_frame(0, "parity_frame", {38'd0, 1'b0, 12'hFFF, 12'h000, 1'b1}, FB, PU, PE, GA, 1'b0, -1);

        // Verbatim frame.
        @(negedge clk);
        set_data(1, 64'h2000001);
        launch(1);
        expect_frame(1, "verbatim_frame", 64'h2000001, FB, PU, PE, GA, 1'b0, -1);

        // Start held high: second frame accepted in the done cycle; data changed mid-frame.
        @(negedge clk);
        r1 = rand64();
        r2 = rand64();
        set_data(0, r1);
        set_start(0, 1'b1);
        @(negedge clk);
        set_data(0, r2);
        expect_frame(0, "held_start_1", model_frame(r1, FB, 1'b1), FB, PU, PE, GA, 1'b0, -1);
        @(negedge clk);
        expect_frame(0, "held_start_2", model_frame(r2, FB, 1'b1), FB, PU, PE, GA, 1'b1, -1);
        @(negedge clk);
        check("idle_after_b2b", 0, obs_of(0), 4'b0000);

        // Abort in the 3rd SPACE cycle of bit 10 (t = 10*PE + PU + 2), then a clean frame.
        r1 = rand64();
        set_data(0, r1);
        launch(0);
        expect_frame(0, "abort", model_frame(r1, FB, 1'b1), FB, PU, PE, GA, 1'b0, 10 * PE + PU + 2);
        r2 = rand64();
        set_data(0, r2);
        launch(0);
        expect_frame(0, "after_abort", model_frame(r2, FB, 1'b1), FB, PU, PE, GA, 1'b1, -1);

        // Start and abort together in IDLE: start wins.
        @(negedge clk);
        r1 = rand64();
        set_data(1, r1);
        set_abort(1, 1'b1);
        launch(1);
        set_abort(1, 1'b0);
        expect_frame(1, "start_abort_idle", model_frame(r1, FB, 1'b0), FB, PU, PE, GA, 1'b1, -1);

        // Reset during the D1 pulse of bit 1.
        @(negedge clk);
        set_data(0, 64'h3FFE001);
        launch(0);
        repeat (PE) @(negedge clk);
        check("pre_reset_pulse", PE, obs_of(0), 4'b1010);
        #2 rst = 1'b0;
        #1 check("async_reset", 0, obs_of(0), 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("post_reset_idle", t, obs_of(0), 4'b0000);
        end
        r1 = rand64();
        set_data(0, r1);
        launch(0);
        expect_frame(0, "after_reset", model_frame(r1, FB, 1'b1), FB, PU, PE, GA, 1'b0, -1);

        // 34-bit parity frame with an all-zero payload, then random 34-bit frames.
        @(negedge clk);
        set_data(2, {30'd0, 1'b1, 32'd0, 1'b1});
        launch(2);
        expect_frame(2, "wide_zero", {30'd0, 1'b0, 32'd0, 1'b1}, CFB, CPU, CPE, CGA, 1'b0, -1);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            r1 = rand64();
            set_data(2, r1);
            launch(2);
            expect_frame(2, "wide_rand", model_frame(r1, CFB, 1'b1), CFB, CPU, CPE, CGA, 1'b1, -1);
        end

        // Random frames on both 26-bit variants.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            r1 = rand64();
            r2 = rand64();
            set_data(0, r1);
            set_data(1, r2);
            launch(0);
            expect_frame(0, "rand_parity", model_frame(r1, FB, 1'b1), FB, PU, PE, GA, 1'b1, -1);
            @(negedge clk);
            launch(1);
            expect_frame(1, "rand_verbatim", model_frame(r2, FB, 1'b0), FB, PU, PE, GA, 1'b1, -1);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wiegand_tx.md
# wiegand_tx

Parametrised Wiegand frame transmitter that replaces the fixed 26-bit free-running output counter. It serialises a latched frame MSB-first onto the D0/D1 pulse pair using a start/busy/done handshake. Frame length, pulse timing and inter-frame gap are parameters, and leading-even/trailing-odd parity can be generated in hardware. It sits between the access-result register block and the external open-collector line drivers.

## Interface
- FRAME_BITS, 26: bits per frame including parity; 4..64; must be even when AUTO_PARITY=1
- PULSE_CYC, 500: clk cycles a data pulse is asserted; ≥1
- PERIOD_CYC, 2200: clk cycles from one pulse start to the next; >PULSE_CYC
- GAP_CYC, 20000: idle cycles after the last pulse ends, before done; ≥1
- AUTO_PARITY, 1: 1 = replace data[FRAME_BITS-1] and data[0] with computed parity; 0 = send data verbatim
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- abort  in  1  terminates the frame in progress; ignored in IDLE
- data  in  FRAME_BITS  frame, MSB sent first; sampled only on accepted start
- wigend  out  2  [1]=D1 pulse (bit '1'), [0]=D0 pulse (bit '0'); active high, idle 00
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse at normal frame completion

## Operation
- States: IDLE, PULSE, SPACE, GAP. A cycle counter (width clog2 of max(PERIOD_CYC, GAP_CYC)) and a bit index (clog2(FRAME_BITS)) run the FSM; the latched frame is held in a shift register.
- IDLE: wigend=00, busy=0. If start=1, latch frame into shift register, set bit index to 0, go to PULSE.
- Parity (AUTO_PARITY=1), computed from data at latch time:
  - frame[FRAME_BITS-1] = XOR(data[FRAME_BITS-2 : FRAME_BITS/2]), i.e. even parity.
  - frame[0] = ~XOR(data[FRAME_BITS/2-1 : 1]), i.e. odd parity.
  - All other bits are copied from data.
- PULSE: drive wigend = {b, ~b}, where b = current frame MSB, for PULSE_CYC cycles.
  - Bits remain → SPACE.
  - Last bit → GAP.
- SPACE: wigend=00 for PERIOD_CYC-PULSE_CYC cycles. Then shift the frame left, increment the bit index, go to PULSE.
- GAP: wigend=00 for GAP_CYC cycles. Then go to IDLE with done=1 for one cycle and busy=0 in that same cycle.
- Abort: abort=1 in PULSE, SPACE or GAP → next cycle wigend=00, busy=0, state IDLE, no done pulse. A pulse in flight is truncated.
- start while busy is ignored; the frame is not queued. start=1 in the done cycle is accepted, because the FSM is already in IDLE.
- start and abort both high in IDLE → start wins; abort is ignored in IDLE.
- data changes after acceptance have no effect on the frame.
- wigend is never 11. Both lines are low between pulses.

## Timing
- Reset (async, rst=0): wigend=00, busy=0, done=0, state IDLE, counters 0. Reset mid-frame clears the outputs immediately, with no glitch to 11.
- start sampled high at edge N → busy=1 and first pulse on wigend from edge N+1. All outputs are registered.
- Pulse k (k=0..FRAME_BITS-1) is high for cycles N+1+k·PERIOD_CYC through N+k·PERIOD_CYC+PULSE_CYC inclusive.
- Last pulse ends → GAP_CYC low cycles → done=1, busy=0 at edge N+1+(FRAME_BITS-1)·PERIOD_CYC+PULSE_CYC+GAP_CYC.
- Minimum start-to-start spacing = (FRAME_BITS-1)·PERIOD_CYC+PULSE_CYC+GAP_CYC+1 cycles.
- abort sampled at edge M → outputs idle at edge M+1.

## Test plan
Scenarios 1–3 and 5 use FRAME_BITS=26, PULSE_CYC=2, PERIOD_CYC=5, GAP_CYC=7.

1. Parity frame: AUTO_PARITY=1, data[24:1]=24'hFFF000, start 1 cycle.
   - Bit sequence: 0, twelve 1s, twelve 0s, 1.
   - Each pulse is 2 cycles wide with a 5-cycle pitch.
   - done arrives 135 cycles after start.
2. Verbatim frame: AUTO_PARITY=0, data=26'h2000001.
   - D1 pulses at bits 0 and 25; D0 pulses at the other 24 bits.
   - wigend never equals 11.
3. Busy and back-to-back starts: start held high continuously.
   - The second frame's first pulse begins 1 cycle after done.
   - Pulses of start during busy produce no extra frames.
4. Abort: abort asserted in the 3rd cycle of bit 10's SPACE.
   - wigend=00 and busy=0 on the next cycle; done never asserts.
   - A new start is then accepted normally.
5. Reset mid-pulse: rst dropped during a D1 pulse.
   - wigend=00 immediately; busy=0.
   - After release, the FSM is in IDLE and no done is seen.
6. Default parameters, FRAME_BITS=34, AUTO_PARITY=1, data[32:1]=0.
   - Sequence: 0, thirty-two 0s, 1.
   - done arrives 33·2200+500+20000+1 cycles after start.
